// File: rtl/zebra_pkg.sv
// Shared FSM encoding, default thresholds and column mapping for the zebra scan scheduler.
package zebra_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    WAIT_SOF = 3'd2,
    RUN      = 3'd3,
    ACCUM    = 3'd4,
    DECIDE   = 3'd5,
    EMIT     = 3'd6
  } sched_state_t;

  localparam int unsigned IMG_WIDTH_DEF      = 320;
  localparam int unsigned N_COLS_DEF         = 4;
  localparam int unsigned COL_BASE_DEF       = 64;
  localparam int unsigned COL_STEP_DEF       = 64;
  localparam int unsigned VOTE_MIN_DEF       = 3;
  localparam int unsigned CONFIRM_SWEEPS_DEF = 2;
  localparam int unsigned RELEASE_SWEEPS_DEF = 3;

  // Caller truncates the result to its column width.
  function automatic int unsigned col_of(input int unsigned idx,
                                         input int unsigned base = COL_BASE_DEF,
                                         input int unsigned step = COL_STEP_DEF);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/zebra_hysteresis.sv
// Sweep-level confirm/release debounce: a run of positive sweeps sets present,
// a run of negative sweeps clears it.
module zebra_hysteresis
  import zebra_pkg::*;
#(
  parameter int unsigned CONFIRM_SWEEPS = CONFIRM_SWEEPS_DEF,
  parameter int unsigned RELEASE_SWEEPS = RELEASE_SWEEPS_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic upd,
  input  logic pos,
  output logic present
);

  localparam int unsigned PW = $clog2(CONFIRM_SWEEPS + 1);
  localparam int unsigned NW = $clog2(RELEASE_SWEEPS + 1);

  logic [PW-1:0] pos_cnt_q;
  logic [NW-1:0] neg_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      pos_cnt_q <= '0;
      neg_cnt_q <= '0;
      present   <= 1'b0;
    end else if (upd) begin
      if (pos) begin
        neg_cnt_q <= '0;
        if (pos_cnt_q != PW'(CONFIRM_SWEEPS)) pos_cnt_q <= pos_cnt_q + 1'b1;
        // Counter is about to reach (or already holds) the confirm threshold.
        if (pos_cnt_q >= PW'(CONFIRM_SWEEPS - 1)) present <= 1'b1;
      end else begin
        pos_cnt_q <= '0;
        if (neg_cnt_q != NW'(RELEASE_SWEEPS)) neg_cnt_q <= neg_cnt_q + 1'b1;
        if (neg_cnt_q >= NW'(RELEASE_SWEEPS - 1)) present <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/zebra_scan_scheduler.sv
// Frame-level sweep controller for zebra_crossing_detector: one column per frame, vote, debounce.
// Optional ZEBRA_SCHED_STATS_EN adds saturating sweep/hit/miss counters.
module zebra_scan_scheduler
  import zebra_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = IMG_WIDTH_DEF,
  parameter int unsigned N_COLS         = N_COLS_DEF,
  parameter int unsigned COL_BASE       = COL_BASE_DEF,
  parameter int unsigned COL_STEP       = COL_STEP_DEF,
  parameter int unsigned VOTE_MIN       = VOTE_MIN_DEF,
  parameter int unsigned CONFIRM_SWEEPS = CONFIRM_SWEEPS_DEF,
  parameter int unsigned RELEASE_SWEEPS = RELEASE_SWEEPS_DEF,
  localparam int unsigned CW = $clog2(IMG_WIDTH),
  localparam int unsigned IW = $clog2(N_COLS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          sof,
  output logic          cfg_valid,
  input  logic          cfg_ready,
  output logic [CW-1:0] cfg_col,
  input  logic          det_valid,
  input  logic          det_hit,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          res_present,
  output logic [IW-1:0] res_votes,
  output logic [2:0]    state_dbg
`ifdef ZEBRA_SCHED_STATS_EN
  ,
  output logic [15:0]   sweep_cnt,
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  if (COL_BASE + (N_COLS - 1) * COL_STEP >= IMG_WIDTH) begin : g_bad_col_range
    $error("zebra_scan_scheduler: last sweep column lies outside the frame");
  end
  if (VOTE_MIN < 1 || VOTE_MIN > N_COLS) begin : g_bad_vote_min
    $error("zebra_scan_scheduler: VOTE_MIN must be within 1..N_COLS");
  end

  sched_state_t  state_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] votes_q;
  logic          hit_q;
  logic          sweep_pos;
  logic          hyst_upd;

  assign sweep_pos = (votes_q >= IW'(VOTE_MIN));
  assign hyst_upd  = (state_q == DECIDE);
  assign state_dbg = state_q;

  // Present only moves in DECIDE, so it is stable for the whole EMIT handshake.
  zebra_hysteresis #(
    .CONFIRM_SWEEPS (CONFIRM_SWEEPS),
    .RELEASE_SWEEPS (RELEASE_SWEEPS)
  ) u_hyst (
    .clk     (clk),
    .rst     (rst),
    .clear   (1'b0),
    .upd     (hyst_upd),
    .pos     (sweep_pos),
    .present (res_present)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      votes_q   <= '0;
      hit_q     <= 1'b0;
      cfg_valid <= 1'b0;
      cfg_col   <= '0;
      res_valid <= 1'b0;
      res_votes <= '0;
    end else if (!enable && state_q != EMIT) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      votes_q   <= '0;
      cfg_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= LOAD;
          cfg_valid <= 1'b1;
          cfg_col   <= CW'(col_of(32'(idx_q), COL_BASE, COL_STEP));
        end
        LOAD: begin
          if (cfg_ready) begin
            state_q   <= WAIT_SOF;
            cfg_valid <= 1'b0;
          end
        end
        WAIT_SOF: begin
          // A det_valid here reports a frame analysed under the previous column.
          if (sof) state_q <= RUN;
        end
        RUN: begin
          if (det_valid) begin
            hit_q   <= det_hit;
            state_q <= ACCUM;
          end else if (sof) begin
            hit_q   <= 1'b0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (votes_q != IW'(N_COLS)) votes_q <= votes_q + IW'(hit_q);
          if (idx_q == IW'(N_COLS - 1)) begin
            state_q <= DECIDE;
          end else begin
            idx_q     <= idx_q + 1'b1;
            state_q   <= LOAD;
            cfg_valid <= 1'b1;
            cfg_col   <= CW'(col_of(32'(idx_q) + 32'd1, COL_BASE, COL_STEP));
          end
        end
        DECIDE: begin
          res_votes <= votes_q;
          res_valid <= 1'b1;
          idx_q     <= '0;
          votes_q   <= '0;
          state_q   <= EMIT;
        end
        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (enable) begin
              state_q   <= LOAD;
              cfg_valid <= 1'b1;
              cfg_col   <= CW'(col_of(32'd0, COL_BASE, COL_STEP));
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ZEBRA_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sweep_cnt <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      if (state_q == DECIDE && sweep_cnt != 16'hFFFF) sweep_cnt <= sweep_cnt + 16'd1;
      if (state_q == DECIDE && sweep_pos && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (enable && state_q == RUN && sof && !det_valid && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
